led_shift_engine: RTL and testbench



---
 rtl/led_shift_if.sv | 37 +++
 rtl/led_shift_engine.sv | 117 +++++++++++
 tb/tb_led_shift_engine.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/led_shift_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_shift_if                                                  |
// | Brief    : Control/status bundle for led_shift_engine. The load and      |
// |            load_data signals exist only with LED_SHIFT_ENGINE_LOAD_EN.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface led_shift_if #(
  parameter int LED_W = 16
);
  logic             run;
  logic [1:0]       mode;
  logic [LED_W-1:0] led;
  logic             tick;
  logic             wrap;
`ifdef LED_SHIFT_ENGINE_LOAD_EN
  logic             load;
  logic [LED_W-1:0] load_data;
`endif

  modport master (
`ifdef LED_SHIFT_ENGINE_LOAD_EN
    output load, load_data,
`endif
    output run, mode,
    input  led, tick, wrap
  );

  modport slave (
`ifdef LED_SHIFT_ENGINE_LOAD_EN
    input  load, load_data,
`endif
    input  run, mode,
    output led, tick, wrap
  );
endinterface
`default_nettype wire

// File: rtl/led_shift_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_shift_engine                                              |
// | Brief    : Prescaled LED pattern shifter (rotate L/R, bounce, hold).     |
// |            Optional parallel load with LED_SHIFT_ENGINE_LOAD_EN.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module led_shift_engine #(
  parameter int               LED_W    = 16,
  parameter int               TICK_DIV = 5_000_000,
  parameter logic [LED_W-1:0] INIT     = LED_W'(1)
) (
  input  wire logic  sys_clk,
  input  wire logic  sys_rst,
  led_shift_if.slave bus
);

  localparam int               c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] c_MODE_ROL    = 2'd0;
  localparam logic [1:0] c_MODE_ROR    = 2'd1;
  localparam logic [1:0] c_MODE_BOUNCE = 2'd2;

  localparam logic [0:0] c_DIR_LEFT  = 1'b0;
  localparam logic [0:0] c_DIR_RIGHT = 1'b1;

  logic [c_CNT_W-1:0] r_cnt;
  logic [LED_W-1:0]   r_led;
  logic [0:0]         r_dir;
  logic               r_tick;
  logic               r_wrap;

  logic               w_step;
  logic               w_zero;
  logic [LED_W-1:0]   w_led_nxt;
  logic [0:0]         w_dir_nxt;
  logic               w_wrap_nxt;

  assign w_step = bus.run && (r_cnt == c_CNT_MAX);
  assign w_zero = ~|r_led;

  always_comb begin
    w_led_nxt  = r_led;
    w_dir_nxt  = r_dir;
    w_wrap_nxt = 1'b0;
    if (w_step) begin
      case (bus.mode)
        c_MODE_ROL: begin
          w_led_nxt  = {r_led[LED_W-2:0], r_led[LED_W-1]};
          w_wrap_nxt = r_led[LED_W-1];
          // An empty pattern must not disturb the bounce direction.
          if (!w_zero) w_dir_nxt = c_DIR_LEFT;
        end
        c_MODE_ROR: begin
          w_led_nxt  = {r_led[0], r_led[LED_W-1:1]};
          w_wrap_nxt = r_led[0];
          if (!w_zero) w_dir_nxt = c_DIR_RIGHT;
        end
        c_MODE_BOUNCE: begin
          if (r_dir == c_DIR_LEFT) begin
            if (r_led[LED_W-1]) begin
              w_dir_nxt  = c_DIR_RIGHT;
              w_led_nxt  = r_led >> 1;
              w_wrap_nxt = 1'b1;
            end else begin
              w_led_nxt  = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_dir_nxt  = c_DIR_LEFT;
              w_led_nxt  = r_led << 1;
              w_wrap_nxt = 1'b1;
            end else begin
              w_led_nxt  = r_led >> 1;
            end
          end
        end
        default: begin
          w_led_nxt = r_led;
        end
      endcase
    end
`ifdef LED_SHIFT_ENGINE_LOAD_EN
    // Load overrides the shift of a coincident step; tick is unaffected.
    if (bus.load) begin
      w_led_nxt  = bus.load_data;
      w_dir_nxt  = c_DIR_LEFT;
      w_wrap_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt  <= '0;
      r_led  <= INIT;
      r_dir  <= c_DIR_LEFT;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (bus.run) begin
        r_cnt <= w_step ? '0 : r_cnt + c_CNT_W'(1);
      end
      r_led  <= w_led_nxt;
      r_dir  <= w_dir_nxt;
      r_tick <= w_step;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bus.led  = r_led;
  assign bus.tick = r_tick;
  assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_shift_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_led_shift_engine                                           |
// | Brief    : Directed self-checking bench for led_shift_engine (8-bit and  |
// |            4-bit instances; load test with LED_SHIFT_ENGINE_LOAD_EN).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_led_shift_engine;

  logic sys_clk;
  logic sys_rst;

  int n_total = 0;
  int n_bad   = 0;

  led_shift_if #(.LED_W(8)) u_if8 ();
  led_shift_if #(.LED_W(4)) u_if4 ();

  led_shift_engine #(.LED_W(8), .TICK_DIV(4), .INIT(8'h01)) u_dut8 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (u_if8)
  );

  led_shift_engine #(.LED_W(4), .TICK_DIV(1), .INIT(4'h1)) u_dut4 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (u_if4)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clk_edge();
    @(posedge sys_clk);
    #1;
  endtask

  // Pulse reset across one edge; releases 1 ns after it, so the next edge is edge 1.
  task automatic do_reset();
    sys_rst = 1'b1;
    clk_edge();
    sys_rst = 1'b0;
  endtask

  logic [7:0] rol_led  [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic       rol_wrap [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] bnc_led  [7] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
  logic       bnc_wrap [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic seen_tick;
    sys_rst    = 1'b1;
    u_if8.run  = 1'b1;
    u_if8.mode = 2'd0;
    u_if4.run  = 1'b0;
    u_if4.mode = 2'd0;
`ifdef LED_SHIFT_ENGINE_LOAD_EN
    u_if8.load      = 1'b0;
    u_if8.load_data = 8'h00;
    u_if4.load      = 1'b0;
    u_if4.load_data = 4'h0;
`endif
    repeat (2) clk_edge();
    check("rst_led8",  u_if8.led,  8'h01);
    check("rst_tick8", u_if8.tick, 1'b0);
    check("rst_wrap8", u_if8.wrap, 1'b0);
    check("rst_led4",  u_if4.led,  4'h1);
    sys_rst = 1'b0;

    // Rotate left: steps at every 4th edge, full circle in 8 steps
    for (int e = 1; e <= 32; e++) begin
      clk_edge();
      if (e % 4 == 0) begin
        check("rol_led",  u_if8.led,  rol_led[e/4-1]);
        check("rol_tick", u_if8.tick, 1'b1);
        check("rol_wrap", u_if8.wrap, rol_wrap[e/4-1]);
      end else begin
        check("rol_idle_tick", u_if8.tick, 1'b0);
        if (e < 4) check("rol_first_led", u_if8.led, 8'h01);
      end
    end

    // Rotate right from reset
    u_if8.mode = 2'd1;
    do_reset();
    repeat (3) clk_edge();
    check("ror_pre_tick", u_if8.tick, 1'b0);
    clk_edge();
    check("ror_led1",  u_if8.led,  8'h80);
    check("ror_wrap1", u_if8.wrap, 1'b1);
    repeat (4) clk_edge();
    check("ror_led2",  u_if8.led,  8'h40);
    check("ror_wrap2", u_if8.wrap, 1'b0);
    check("ror_tick2", u_if8.tick, 1'b1);

    // Pause after 2 counts for 10 cycles
    repeat (2) clk_edge();
    u_if8.run = 1'b0;
    seen_tick = 1'b0;
    repeat (10) begin
      clk_edge();
      seen_tick |= u_if8.tick;
    end
    check("pause_tick", seen_tick, 1'b0);
    check("pause_led",  u_if8.led, 8'h40);
    u_if8.run = 1'b1;
    clk_edge();
    check("resume_early_tick", u_if8.tick, 1'b0);
    clk_edge();
    check("resume_tick", u_if8.tick, 1'b1);
    check("resume_led",  u_if8.led,  8'h20);

    // Hold: tick continues every 4 cycles, pattern frozen
    u_if8.mode = 2'd3;
    for (int i = 0; i < 12; i++) begin
      clk_edge();
      check("hold_tick", u_if8.tick, (i % 4 == 3) ? 1'b1 : 1'b0);
      if (i % 4 == 3) check("hold_wrap", u_if8.wrap, 1'b0);
    end
    check("hold_led", u_if8.led, 8'h20);

    // Asynchronous reset between edges
    u_if8.mode = 2'd1;
    repeat (4) clk_edge();
    check("pre_arst_led",  u_if8.led,  8'h10);
    check("pre_arst_tick", u_if8.tick, 1'b1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("arst_led",  u_if8.led,  8'h01);
    check("arst_tick", u_if8.tick, 1'b0);
    u_if8.mode = 2'd0;
    clk_edge();
    sys_rst = 1'b0;
    repeat (3) clk_edge();
    check("arst_pre_tick", u_if8.tick, 1'b0);
    clk_edge();
    check("arst_step_tick", u_if8.tick, 1'b1);
    check("arst_step_led",  u_if8.led,  8'h02);

    // Bounce on the 4-bit instance, step every cycle
    u_if4.mode = 2'd2;
    u_if4.run  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      clk_edge();
      check("bnc_led",  u_if4.led,  bnc_led[i]);
      check("bnc_wrap", u_if4.wrap, bnc_wrap[i]);
      check("bnc_tick", u_if4.tick, 1'b1);
    end

`ifdef LED_SHIFT_ENGINE_LOAD_EN
    // Load coincident with a step, then rotate left
    u_if8.mode = 2'd0;
    do_reset();
    repeat (3) clk_edge();
    u_if8.load      = 1'b1;
    u_if8.load_data = 8'hA5;
    clk_edge();
    u_if8.load = 1'b0;
    check("load_led",  u_if8.led,  8'hA5);
    check("load_tick", u_if8.tick, 1'b1);
    check("load_wrap", u_if8.wrap, 1'b0);
    repeat (4) clk_edge();
    check("load_rol_led",  u_if8.led,  8'h4B);
    check("load_rol_wrap", u_if8.wrap, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
